// File: rtl/tblink_rpc_pktfifo_pkg.sv
// Shared packet framing definitions and input-FSM state type for the RPC packet FIFO.
// The framing constants are reused by the endpoint and the command processor.
package tblink_rpc_pktfifo_pkg;

  localparam int unsigned PKT_HDR_LEN     = 2;
  localparam int unsigned PKT_HDR_DST_OFF = 0;
  localparam int unsigned PKT_HDR_SZ_OFF  = PKT_HDR_LEN - 1;
  localparam int unsigned PKT_MAX_SZ      = 255;

  typedef enum logic [1:0] {
    HDR_DST = 2'd0,
    HDR_SZ  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } pktfifo_state_t;

endpackage

// File: rtl/tblink_rpc_pktfifo_mem.sv
// Byte-wide 1W/1R synchronous dual-port RAM with a registered read port.
module tblink_rpc_pktfifo_mem #(
  parameter int unsigned AW = 9
) (
  input  logic          uclock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge uclock) begin : p_ram
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tblink_rpc_pktfifo.sv
// Store-and-forward packet FIFO feeding neti_: bytes leave only once their whole packet is buffered.
// Define TBLINK_RPC_PKTFIFO_STATS_EN to add committed/dropped packet counters.
module tblink_rpc_pktfifo
  import tblink_rpc_pktfifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                uclock,
  input  logic                reset,
  input  logic [7:0]          t_dat,
  input  logic                t_valid,
  output logic                t_ready,
  output logic [7:0]          i_dat,
  output logic                i_valid,
  input  logic                i_ready,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow
`ifdef TBLINK_RPC_PKTFIFO_STATS_EN
  ,
  output logic [15:0]         pkt_in_cnt,
  output logic [15:0]         pkt_drop_cnt
`endif
);

  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned RW    = $clog2(PKT_MAX_SZ + 1);

  typedef logic [PW-1:0] ptr_t;

  pktfifo_state_t state, state_nx;
  ptr_t           wr_ptr, wr_ptr_nx, commit_ptr, commit_ptr_nx;
  ptr_t           rd_ptr, rd_ptr_nx, f_ptr, f_ptr_nx, inflight;
  logic [RW-1:0]  remain, remain_nx;
  logic           drop_sz, drop_sz_nx;
  logic           overflow_nx, t_ready_nx, i_valid_nx, q_valid, q_valid_nx;
  logic [7:0]     i_dat_nx, q_dat;
  logic [PW-1:0]  level_nx;
  logic           accept, pop, full, mem_we, commit, rd_en, out_load;

  tblink_rpc_pktfifo_mem #(.AW(DEPTH_LOG2)) u_mem (
    .uclock (uclock),
    .we     (mem_we),
    .waddr  (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata  (t_dat),
    .re     (rd_en),
    .raddr  (f_ptr[DEPTH_LOG2-1:0]),
    .rdata  (q_dat)
  );

  // Input FSM, pointer bookkeeping and show-ahead output staging.
  always_comb begin : p_next
    state_nx      = state;
    wr_ptr_nx     = wr_ptr;
    commit_ptr_nx = commit_ptr;
    remain_nx     = remain;
    drop_sz_nx    = drop_sz;
    overflow_nx   = overflow;
    mem_we        = 1'b0;
    commit        = 1'b0;

    accept   = t_valid & t_ready;
    pop      = i_valid & i_ready;
    full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
    inflight = wr_ptr - commit_ptr;

    // A packet that fills the buffer with nothing left to drain can never fit: drop it whole.
    if (full && (commit_ptr == rd_ptr) && (state != DROP) &&
        (inflight != PW'(PKT_HDR_DST_OFF))) begin
      wr_ptr_nx   = commit_ptr;
      overflow_nx = 1'b1;
      state_nx    = DROP;
      drop_sz_nx  = (inflight == PW'(PKT_HDR_SZ_OFF));
    end else if (accept) begin
      case (state)
        HDR_DST: begin
          mem_we   = 1'b1;
          state_nx = HDR_SZ;
        end
        HDR_SZ: begin
          mem_we    = 1'b1;
          remain_nx = RW'(t_dat);
          if (t_dat == 8'd0) begin
            commit   = 1'b1;
            state_nx = HDR_DST;
          end else begin
            state_nx = PAYLOAD;
          end
        end
        PAYLOAD: begin
          mem_we    = 1'b1;
          remain_nx = remain - RW'(1);
          if (remain == RW'(1)) begin
            commit   = 1'b1;
            state_nx = HDR_DST;
          end
        end
        default: begin
          if (drop_sz) begin
            drop_sz_nx = 1'b0;
            remain_nx  = RW'(t_dat);
            if (t_dat == 8'd0) state_nx = HDR_DST;
          end else begin
            remain_nx = remain - RW'(1);
            if (remain == RW'(1)) state_nx = HDR_DST;
          end
        end
      endcase
    end

    if (mem_we) wr_ptr_nx = wr_ptr + PW'(1);
    if (commit) commit_ptr_nx = wr_ptr + PW'(1);

    // Two-stage read: RAM read register then output register, refilled whenever either frees up.
    out_load   = q_valid & (~i_valid | pop);
    rd_en      = (f_ptr != commit_ptr) & (~q_valid | out_load);
    f_ptr_nx   = rd_en ? f_ptr + PW'(1) : f_ptr;
    q_valid_nx = rd_en | (q_valid & ~out_load);
    i_valid_nx = out_load | (i_valid & ~pop);
    i_dat_nx   = out_load ? q_dat : i_dat;
    rd_ptr_nx  = pop ? rd_ptr + PW'(1) : rd_ptr;

    level_nx   = wr_ptr_nx - rd_ptr_nx;
    t_ready_nx = (level_nx != PW'(DEPTH)) | (state_nx == DROP);
  end

  always_ff @(posedge uclock or posedge reset) begin : p_state
    if (reset) state <= HDR_DST;
    else       state <= state_nx;
  end

  always_ff @(posedge uclock or posedge reset) begin : p_regs
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      f_ptr      <= '0;
      remain     <= '0;
      drop_sz    <= 1'b0;
      overflow   <= 1'b0;
      t_ready    <= 1'b0;
      q_valid    <= 1'b0;
      i_valid    <= 1'b0;
      i_dat      <= '0;
      level      <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nx;
      commit_ptr <= commit_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      f_ptr      <= f_ptr_nx;
      remain     <= remain_nx;
      drop_sz    <= drop_sz_nx;
      overflow   <= overflow_nx;
      t_ready    <= t_ready_nx;
      q_valid    <= q_valid_nx;
      i_valid    <= i_valid_nx;
      i_dat      <= i_dat_nx;
      level      <= level_nx;
    end
  end

`ifdef TBLINK_RPC_PKTFIFO_STATS_EN
  always_ff @(posedge uclock or posedge reset) begin : p_stats
    if (reset) begin
      pkt_in_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (commit) pkt_in_cnt <= pkt_in_cnt + 16'd1;
      if ((state_nx == DROP) && (state != DROP)) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
    end
  end
`endif

endmodule
